// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable Mealy sequence detector on a SYM_W-bit
// symbol stream, with per-position don't-care mask, overlap/non-overlap mode,
// valid-qualified input and a saturating match counter.
//
// Ports:
//   clk, clr_n       clock, asynchronous active-low reset
//   in_valid, in_sym input symbol stream
//   cfg_we/idx/sym/dc pattern entry write (position 0 = first symbol)
//   ctl_we/len/ovl/en control write (length, overlap mode, enable)
//   cnt_clr          synchronous clear of match_cnt
//   Z                combinational match flag (same cycle as final symbol)
//   z_q              Z delayed by one clock
//   match_cnt        saturating match count
module seq_detect_param #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic             cfg_dc,
  input  logic             ctl_we,
  input  logic [LEN_W-1:0] ctl_len,
  input  logic             ctl_ovl,
  input  logic             ctl_en,
  input  logic             cnt_clr,
  output logic             Z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned HIST_N = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;
  localparam int unsigned HIDX_W = (HIST_N > 1) ? $clog2(HIST_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYM_W-1:0]   pat_q  [MAX_LEN];
  logic [SYM_W-1:0]   pat_d  [MAX_LEN];
  logic [MAX_LEN-1:0] dc_q, dc_d;
  logic [SYM_W-1:0]   hist_q [HIST_N];
  logic [SYM_W-1:0]   hist_d [HIST_N];
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               en_q, en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               hit;
  logic [IDX_W-1:0]   last_idx;
  logic [HIDX_W-1:0]  h_idx;

  // Match evaluation: pattern position p lines up with hist[len-2-p],
  // the final position with the symbol arriving this cycle.
  always_comb begin
    accept   = in_valid & ~cfg_we & ~ctl_we;
    last_idx = IDX_W'(len_q - LEN_W'(1));
    h_idx    = '0;
    hit      = (fill_q >= len_q - LEN_W'(1)) &&
               (dc_q[last_idx] || (in_sym == pat_q[last_idx]));
    for (int unsigned p = 0; p < HIST_N; p++) begin
      if (LEN_W'(p) + LEN_W'(1) < len_q) begin
        h_idx = HIDX_W'(len_q - LEN_W'(2) - LEN_W'(p));
        if (!(dc_q[IDX_W'(p)] || (hist_q[h_idx] == pat_q[IDX_W'(p)]))) begin
          hit = 1'b0;
        end
      end
    end
    Z = en_q & accept & hit;
  end

  // Next-state: config writes, history shift, fill tracking, counter.
  always_comb begin
    pat_d  = pat_q;
    dc_d   = dc_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    en_d   = en_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;

    if (cfg_we) begin
      pat_d[cfg_idx] = cfg_sym;
      dc_d[cfg_idx]  = cfg_dc;
    end

    if (ctl_we) begin
      if (ctl_len == '0) begin
        len_d = LEN_W'(1);
      end else if (ctl_len > LEN_W'(MAX_LEN)) begin
        len_d = LEN_W'(MAX_LEN);
      end else begin
        len_d = ctl_len;
      end
      ovl_d = ctl_ovl;
      en_d  = ctl_en;
    end

    // Any config write flushes partial progress.
    if (cfg_we || ctl_we) begin
      fill_d = '0;
    end else if (accept) begin
      hist_d[0] = in_sym;
      for (int unsigned i = 1; i < HIST_N; i++) begin
        hist_d[HIDX_W'(i)] = hist_q[HIDX_W'(i - 1)];
      end
      if (Z && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (Z && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        pat_q[i] <= '0;
      end
      for (int unsigned i = 0; i < HIST_N; i++) begin
        hist_q[i] <= '0;
      end
      dc_q   <= '0;
      len_q  <= LEN_W'(1);
      ovl_q  <= 1'b1;
      en_q   <= 1'b0;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      dc_q   <= dc_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      en_q   <= en_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= Z;
    end
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param (SYM_W=2, MAX_LEN=8, CNT_W=2).
// Driver tasks apply one cycle of stimulus at posedge+1 and queue the expected
// {Z, z_q, match_cnt}; the monitor pops and compares at every negedge.
module tb_seq_detect_param;

  logic       clk;
  logic       clr_n;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [1:0] cfg_sym;
  logic       cfg_dc;
  logic       ctl_we;
  logic [3:0] ctl_len;
  logic       ctl_ovl;
  logic       ctl_en;
  logic       cnt_clr;
  logic       Z;
  logic       z_q;
  logic [1:0] match_cnt;

  seq_detect_param #(.SYM_W(2), .MAX_LEN(8), .CNT_W(2)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_sym   (cfg_sym),
    .cfg_dc    (cfg_dc),
    .ctl_we    (ctl_we),
    .ctl_len   (ctl_len),
    .ctl_ovl   (ctl_ovl),
    .ctl_en    (ctl_en),
    .cnt_clr   (cnt_clr),
    .Z         (Z),
    .z_q       (z_q),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       z;
    logic       zq;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic       chk_vld;
  logic       zq_m;
  logic [1:0] cnt_m;
  int         n_chk;
  int         n_pass;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
  endtask

  // Monitor: one expected record per checked cycle.
  always @(negedge clk) begin
    exp_t e;
    if (chk_vld) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_empty actual=0 required>0 at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("Z", {1'b0, Z}, {1'b0, e.z});
        chk("z_q", {1'b0, z_q}, {1'b0, e.zq});
        chk("match_cnt", match_cnt, e.cnt);
      end
    end
  end

  task automatic quiet();
    in_valid = 1'b0; in_sym = 2'd0;
    cfg_we = 1'b0; cfg_idx = 3'd0; cfg_sym = 2'd0; cfg_dc = 1'b0;
    ctl_we = 1'b0; ctl_len = 4'd0; ctl_ovl = 1'b0; ctl_en = 1'b0;
    cnt_clr = 1'b0;
  endtask

  // Queue the expectation for this cycle; z_q/count carry the hand-given Z.
  task automatic push(input logic ez, input logic [1:0] ecnt);
    exp_t e;
    e.z = ez; e.zq = zq_m; e.cnt = ecnt;
    sb.push_back(e);
    chk_vld = 1'b1;
    zq_m  = ez;
    cnt_m = ecnt;
    if (cnt_clr) cnt_m = 2'd0;
    else if (ez && cnt_m != 2'd3) cnt_m = cnt_m + 2'd1;
  endtask

  task automatic sym(input logic [1:0] s, input logic ez);
    @(posedge clk); #1; quiet(); in_valid = 1'b1; in_sym = s; push(ez, cnt_m);
  endtask

  task automatic sym_clr(input logic [1:0] s, input logic ez);
    @(posedge clk); #1; quiet(); in_valid = 1'b1; in_sym = s; cnt_clr = 1'b1; push(ez, cnt_m);
  endtask

  task automatic gap();
    @(posedge clk); #1; quiet(); in_sym = 2'd2; push(1'b0, cnt_m);
  endtask

  task automatic idle_cnt(input logic [1:0] c);
    @(posedge clk); #1; quiet(); push(1'b0, c);
  endtask

  task automatic clr_cnt();
    @(posedge clk); #1; quiet(); cnt_clr = 1'b1; push(1'b0, cnt_m);
  endtask

  // Pattern write; a valid symbol is offered too and must be ignored.
  task automatic wpat(input logic [2:0] idx, input logic [1:0] s, input logic d);
    @(posedge clk); #1; quiet();
    cfg_we = 1'b1; cfg_idx = idx; cfg_sym = s; cfg_dc = d;
    in_valid = 1'b1; in_sym = 2'd3;
    push(1'b0, cnt_m);
  endtask

  task automatic wctl(input logic [3:0] l, input logic o, input logic e);
    @(posedge clk); #1; quiet();
    ctl_we = 1'b1; ctl_len = l; ctl_ovl = o; ctl_en = e;
    push(1'b0, cnt_m);
  endtask

  // Reset asserted mid-cycle on top of a matching symbol.
  task automatic rst_mid(input logic [1:0] s);
    @(posedge clk); #1; quiet(); in_valid = 1'b1; in_sym = s;
    #1 clr_n = 1'b0;
    zq_m = 1'b0; cnt_m = 2'd0;
    push(1'b0, 2'd0);
    @(negedge clk); #1 clr_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    chk_vld = 1'b0; zq_m = 1'b0; cnt_m = 2'd0;
    clr_n = 1'b0;
    quiet();
    repeat (2) @(posedge clk);
    // Reset state observed while clr_n is low.
    @(posedge clk); #1; quiet(); in_valid = 1'b1; in_sym = 2'd1; push(1'b0, 2'd0);
    @(negedge clk); #1 clr_n = 1'b1;

    // Disabled after reset: nothing matches.
    sym(2'd1, 0); sym(2'd3, 0); sym(2'd3, 0); sym(2'd1, 0);
    idle_cnt(2'd0);

    // Basic match {1,3,3}.
    wpat(3'd0, 2'd1, 0); wpat(3'd1, 2'd3, 0); wpat(3'd2, 2'd3, 0);
    wctl(4'd3, 1, 1);
    sym(2'd1, 0); sym(2'd3, 0); sym(2'd3, 1); sym(2'd3, 0);
    sym(2'd1, 0); sym(2'd3, 0); sym(2'd3, 1);
    idle_cnt(2'd2); clr_cnt();

    // Overlap {1,1}.
    wpat(3'd0, 2'd1, 0); wpat(3'd1, 2'd1, 0); wctl(4'd2, 1, 1);
    sym(2'd1, 0); sym(2'd1, 1); sym(2'd1, 1); sym(2'd1, 1);
    idle_cnt(2'd3); clr_cnt();
    // Non-overlap {1,1}.
    wctl(4'd2, 0, 1);
    sym(2'd1, 0); sym(2'd1, 1); sym(2'd1, 0); sym(2'd1, 1);
    idle_cnt(2'd2); clr_cnt();

    // Don't-care middle position and invalid gaps.
    wpat(3'd0, 2'd0, 0); wpat(3'd1, 2'd0, 1); wpat(3'd2, 2'd2, 0);
    wctl(4'd3, 1, 1);
    sym(2'd0, 0); sym(2'd3, 0); sym(2'd2, 1); sym(2'd0, 0);
    gap(); gap();
    sym(2'd1, 0); sym(2'd2, 1);
    idle_cnt(2'd2); clr_cnt();

    // Flush breaks a partial sequence.
    wpat(3'd0, 2'd1, 0); wpat(3'd1, 2'd3, 0); wpat(3'd2, 2'd3, 0);
    wctl(4'd3, 1, 1);
    sym(2'd1, 0); sym(2'd3, 0);
    wpat(3'd0, 2'd1, 0);
    sym(2'd3, 0);
    sym(2'd1, 0); sym(2'd3, 0); sym(2'd3, 1);
    idle_cnt(2'd1); clr_cnt();

    // Length above MAX_LEN clamps to 8: pattern {1,3,3,0,0,0,0,0}.
    wctl(4'd15, 1, 1);
    sym(2'd1, 0); sym(2'd3, 0); sym(2'd3, 0); sym(2'd0, 0);
    sym(2'd0, 0); sym(2'd0, 0); sym(2'd0, 0); sym(2'd0, 1);
    idle_cnt(2'd1); clr_cnt();

    // Length 0 stored as 1; counter saturation and clear priority.
    wpat(3'd0, 2'd2, 0); wctl(4'd0, 1, 1);
    sym(2'd2, 1); sym(2'd2, 1); sym(2'd2, 1); sym(2'd2, 1); sym(2'd2, 1);
    idle_cnt(2'd3);
    sym_clr(2'd2, 1);
    idle_cnt(2'd0);
    sym(2'd1, 0);
    sym(2'd2, 1);

    // Asynchronous reset mid-stream, then disabled.
    rst_mid(2'd2);
    sym(2'd2, 0); sym(2'd2, 0);
    idle_cnt(2'd0);

    @(posedge clk); #1; quiet(); chk_vld = 1'b0;
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable Mealy sequence detector for a stream of SYM_W-bit symbols. It generalises the fixed two-input pattern detectors in the sequential-logic set with these additions:
- pattern length up to MAX_LEN
- per-position don't-care mask
- overlap / non-overlap mode
- valid-qualified input
- saturating match counter

It sits directly on a symbol stream and flags pattern completion in the same cycle as the final symbol.

## Interface
Parameters:
- SYM_W, 2, symbol width in bits
- MAX_LEN, 8, maximum pattern length (≥1)
- CNT_W, 8, match counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_sym carries a symbol this cycle
- in_sym  in  SYM_W  input symbol
- cfg_we  in  1  write pattern entry
- cfg_idx  in  $clog2(MAX_LEN)  pattern position written (0 = first symbol of pattern)
- cfg_sym  in  SYM_W  symbol for position cfg_idx
- cfg_dc  in  1  1 = position cfg_idx is don't-care
- ctl_we  in  1  write control fields below
- ctl_len  in  $clog2(MAX_LEN+1)  pattern length
- ctl_ovl  in  1  1 = overlapping matches allowed
- ctl_en  in  1  detector enable
- cnt_clr  in  1  synchronous clear of match_cnt
- Z  out  1  Mealy match flag, combinational
- z_q  out  1  Z registered (one cycle later)
- match_cnt  out  CNT_W  saturating count of matches

## Operation
- State:
  - pat[MAX_LEN], dc[MAX_LEN]
  - len, ovl, en
  - hist[MAX_LEN-1]: accepted symbols, hist[0] newest
  - fill: 0..MAX_LEN, saturating count of symbols accepted since last flush
  - z_q, match_cnt
- Reset (clr_n low, immediate): pat=0, dc=0, len=1, ovl=1, en=0, hist=0, fill=0, z_q=0, match_cnt=0. Z=0 because en=0.
- Length handling: ctl_len=0 is stored as 1. Values >MAX_LEN are clamped to MAX_LEN.
- A symbol is accepted when in_valid=1 and cfg_we=0 and ctl_we=0. Cycles with in_valid=0 leave hist/fill unchanged and do not break a partial sequence.
- Z=1 iff all of the following hold:
  - en and the symbol is accepted
  - fill ≥ len-1
  - (dc[len-1] or in_sym==pat[len-1])
  - for every i in 0..len-2: (dc[len-2-i] or hist[i]==pat[len-2-i])
- On each accepted symbol: hist shifts in in_sym and fill increments (saturating at MAX_LEN).
- Non-overlap mode (ovl=0): a match sets fill to 0, so the matching symbol cannot start or contribute to the next match. Overlap mode keeps fill incrementing.
- Flush: any cycle with cfg_we=1 or ctl_we=1 sets fill to 0. in_sym is ignored that cycle and Z=0. hist contents are don't-care after a flush.
- cfg_we writes pat[cfg_idx]=cfg_sym and dc[cfg_idx]=cfg_dc. ctl_we writes len, ovl and en. cfg_we and ctl_we may both be asserted in the same cycle; both writes take effect.
- match_cnt:
  - increments on Z=1 and saturates at 2^CNT_W-1
  - cnt_clr has priority: if cnt_clr and Z are both high, the result is 0
- en=0: Z=0 and match_cnt holds. Symbols are still accepted into hist/fill.

## Timing
- Z: zero latency, combinational from in_sym/in_valid and registered state, valid in the same cycle as the last pattern symbol.
- z_q and match_cnt update on the clk edge ending that cycle.
- Config written on edge N affects matching from cycle N+1. A full len symbols must then arrive before the first match.
- clr_n asserted mid-sequence: all state clears asynchronously and Z drops immediately. After release, detection starts with en=0.

## Test plan
- Reset/disable: clr_n low then high, en=0, stream 1,3,3,1 → Z=0 throughout, match_cnt=0, z_q=0.
- Basic match, SYM_W=2: pat={1,3,3}, len=3, ovl=1, en=1; stream 1,3,3,3,1,3,3 → Z=1 on the 3rd and 7th symbols only, z_q one cycle later each time, match_cnt=2.
- Overlap vs non-overlap: pat={1,1}, len=2; stream 1,1,1,1 → ovl=1 gives Z on symbols 2,3,4 and match_cnt=3; ovl=0 gives Z on symbols 2,4 and match_cnt=2.
- Don't-care and gaps: pat={0,X,2} with dc[1]=1, len=3; stream 0,3,2,0,1,2 with in_valid=0 for 2 cycles between symbols 4 and 5 → Z on symbols 3 and 6.
- Flush: pat={1,3,3}; send 1,3, then cfg_we pulse, then 3 → no Z. Then 1,3,3 → Z on the final 3.
- Saturation/clear/reset, CNT_W=2, pat={2}, len=1:
  - five matching symbols → match_cnt stays 3
  - cnt_clr together with a match → match_cnt=0
  - clr_n pulsed mid-stream → Z and all outputs 0 immediately, en=0 after release
